// File: rtl/bus_pkg.sv
// bus_pkg
//   Shared encoding for both ends of the 8-bit system bus. The output-select
//   logic and the load controller use the same select bit positions, so a
//   control word means the same thing on either side.
//   Contents: bus/register width, load-select width, error counter width,
//   and the bit index of each destination in the one-hot load vector.
package bus_pkg;

  localparam int DATA_W = 8;
  localparam int N_DEST = 6;
  localparam int ERR_W  = 4;

  localparam int SEL_MEM = 0;
  localparam int SEL_A   = 1;
  localparam int SEL_B   = 2;
  localparam int SEL_MAR = 3;
  localparam int SEL_PC  = 4;
  localparam int SEL_IR  = 5;

endpackage

// File: rtl/load_reg.sv
// load_reg
//   Plain W-bit register with a load enable and asynchronous active-low reset.
//   Ports:
//     clk    in  1  clock, rising edge
//     rst_n  in  1  asynchronous active-low reset, clears q
//     load   in  1  capture d at the next rising edge
//     d      in  W  data to capture
//     q      out W  registered value
module load_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bus_load_ctrl.sv
// bus_load_ctrl
//   Write side of the shared system bus: a one-hot load vector picks which
//   destination (RAM, A, B, MAR, PC, IR) captures the bus value each clock.
//   Also owns PC increment, the one-cycle RAM write strobe and detection of
//   illegal (multi-hot) select vectors.
//   Ports:
//     clk, rst_n          clock and asynchronous active-low reset
//     bus                 value currently on the shared bus
//     in_signals          one-hot load select, bit positions from bus_pkg
//     pc_inc              increment PC when PC is not being loaded
//     err_clr             clear err_multi / err_count
//     A_reg, B_reg, MAR   A, B and memory address registers
//     PC, instr_reg       program counter and instruction register
//     mem_we              one-cycle RAM write pulse
//     mem_addr, mem_wdata RAM write address/data, held between pulses
//     load_strobe         registered copy of the last accepted select
//     err_multi           sticky multi-hot flag
//     err_count           saturating multi-hot event count
module bus_load_ctrl
  import bus_pkg::*;
#(
  parameter int DATA_W = bus_pkg::DATA_W,
  parameter int N_DEST = bus_pkg::N_DEST,
  parameter int ERR_W  = bus_pkg::ERR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus,
  input  logic [N_DEST-1:0] in_signals,
  input  logic              pc_inc,
  input  logic              err_clr,
  output logic [DATA_W-1:0] A_reg,
  output logic [DATA_W-1:0] B_reg,
  output logic [DATA_W-1:0] MAR,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] instr_reg,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [N_DEST-1:0] load_strobe,
  output logic              err_multi,
  output logic [ERR_W-1:0]  err_count
);

  localparam int CNT_W = $clog2(N_DEST + 1);

  logic [CNT_W-1:0] sel_count;
  logic             sel_valid;
  logic             sel_multi;

  // Popcount of the select vector; exactly one bit set is a legal select,
  // two or more is an illegal request that must not load anything.
  always_comb begin
    sel_count = '0;
    for (int i = 0; i < N_DEST; i++) begin
      sel_count = sel_count + CNT_W'(in_signals[i]);
    end
    sel_valid = (sel_count == CNT_W'(1));
    sel_multi = (sel_count > CNT_W'(1));
  end

  load_reg #(.W(DATA_W)) u_a_reg (
    .clk(clk), .rst_n(rst_n), .load(sel_valid && in_signals[SEL_A]),
    .d(bus), .q(A_reg)
  );

  load_reg #(.W(DATA_W)) u_b_reg (
    .clk(clk), .rst_n(rst_n), .load(sel_valid && in_signals[SEL_B]),
    .d(bus), .q(B_reg)
  );

  load_reg #(.W(DATA_W)) u_mar_reg (
    .clk(clk), .rst_n(rst_n), .load(sel_valid && in_signals[SEL_MAR]),
    .d(bus), .q(MAR)
  );

  load_reg #(.W(DATA_W)) u_ir_reg (
    .clk(clk), .rst_n(rst_n), .load(sel_valid && in_signals[SEL_IR]),
    .d(bus), .q(instr_reg)
  );

  // A bus load of PC beats increment; increment still applies on idle and
  // multi-hot cycles because PC is not loaded then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC <= '0;
    end else if (sel_valid && in_signals[SEL_PC]) begin
      PC <= bus;
    end else if (pc_inc) begin
      PC <= PC + DATA_W'(1);
    end
  end

  // RAM write uses MAR as it stood at the sampling edge; a one-hot select
  // cannot load MAR in the same cycle, so there is no bypass to worry about.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= sel_valid && in_signals[SEL_MEM];
      if (sel_valid && in_signals[SEL_MEM]) begin
        mem_addr  <= MAR;
        mem_wdata <= bus;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_strobe <= '0;
    end else begin
      load_strobe <= sel_valid ? in_signals : '0;
    end
  end

  // Clear takes precedence, so a multi-hot event coinciding with err_clr is
  // deliberately lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_multi <= 1'b0;
      err_count <= '0;
    end else if (err_clr) begin
      err_multi <= 1'b0;
      err_count <= '0;
    end else if (sel_multi) begin
      err_multi <= 1'b1;
      if (err_count != {ERR_W{1'b1}}) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule
